// File: rtl/game_over.sv
// Sticky game-over flag driven by the snake collision signal, with a post-reset grace window.
// Optional consecutive-cycle collision filter enabled by defining GAME_OVER_FILTER_EN.
module game_over #(
  parameter int unsigned GRACE_CYCLES  = 4,
  parameter int unsigned FILTER_CYCLES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic collision,
  output logic gameOver
);

  // state       | meaning
  // S_ARMING    | grace window after reset, collision ignored
  // S_PLAYING   | game running, collision qualified
  // S_GAME_OVER | absorbing end state, gameOver=1
  localparam logic [1:0] S_ARMING    = 2'b00;
  localparam logic [1:0] S_PLAYING   = 2'b01;
  localparam logic [1:0] S_GAME_OVER = 2'b10;

  localparam logic [15:0] GRACE_TC = 16'(GRACE_CYCLES);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [15:0] r_grace_cnt;
  logic        r_game_over;
  logic        w_game_over_d;
  logic        w_grace_done;
  logic        w_col_hit;

  assign w_grace_done = (r_grace_cnt == GRACE_TC);

  // Grace counter stays cleared outside ARMING so a recovery from a bad encoding starts fresh.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_grace_cnt <= '0;
    end else if (r_state != S_ARMING) begin
      r_grace_cnt <= '0;
    end else if (!w_grace_done) begin
      r_grace_cnt <= r_grace_cnt + 16'd1;
    end
  end

`ifdef GAME_OVER_FILTER_EN
  localparam logic [7:0] FILT_TC = 8'(FILTER_CYCLES - 1);

  logic [7:0] r_filt_cnt;

  always_ff @(posedge clock) begin
    if (reset || (r_state != S_PLAYING) || !collision) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt != 8'hFF) begin
      r_filt_cnt <= r_filt_cnt + 8'd1;
    end
  end

  assign w_col_hit = collision && (r_filt_cnt >= FILT_TC);
`else
  // FILTER_CYCLES has no effect in this build.
  if (FILTER_CYCLES == 0) begin : g_filter_ignored
  end

  assign w_col_hit = collision;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_ARMING;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_game_over <= w_game_over_d;
    end
  end

  always_comb begin
    w_state_nxt = S_ARMING;
    case (r_state)
      S_ARMING:    w_state_nxt = w_grace_done ? S_PLAYING : S_ARMING;
      S_PLAYING:   w_state_nxt = w_col_hit ? S_GAME_OVER : S_PLAYING;
      S_GAME_OVER: w_state_nxt = S_GAME_OVER;
      default:     w_state_nxt = S_ARMING;
    endcase
  end

  always_comb begin
    w_game_over_d = (w_state_nxt == S_GAME_OVER);
  end

  assign gameOver = r_game_over;

endmodule

// File: tb/tb_game_over.sv
// Self-checking bench for game_over: fixed vector table, directed corner sequences and
// randomized traffic compared against a cycle-counting reference model.
module tb_game_over;

`ifdef GAME_OVER_FILTER_EN
  localparam bit FILT_ON = 1'b1;
`else
  localparam bit FILT_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic collision = 1'b0;
  logic go0, go1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  game_over #(.GRACE_CYCLES(4), .FILTER_CYCLES(2)) u_dut0 (
    .clock(clock), .reset(reset), .collision(collision), .gameOver(go0)
  );

  game_over #(.GRACE_CYCLES(0), .FILTER_CYCLES(3)) u_dut1 (
    .clock(clock), .reset(reset), .collision(collision), .gameOver(go1)
  );

  // Reference model: edges since reset release, run of consecutive qualified highs, sticky flag.
  int m_since[2];
  int m_run[2];
  bit m_over[2];

  task automatic model_step(input int idx, input int g, input int f, input bit rst, input bit col);
    int f_eff;
    f_eff = FILT_ON ? f : 1;
    if (rst) begin
      m_since[idx] = 0;
      m_run[idx]   = 0;
      m_over[idx]  = 1'b0;
    end else begin
      m_since[idx] = m_since[idx] + 1;
      if (!m_over[idx] && m_since[idx] >= g + 2) begin
        m_run[idx] = col ? m_run[idx] + 1 : 0;
        if (m_run[idx] >= f_eff) m_over[idx] = 1'b1;
      end
    end
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: gameOver=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit rst, input bit col, input string name);
    @(negedge clock);
    reset     = rst;
    collision = col;
    @(posedge clock);
    model_step(0, 4, 2, rst, col);
    model_step(1, 0, 3, rst, col);
    #1;
    chk({name, "/g4"}, go0, m_over[0]);
    chk({name, "/g0"}, go1, m_over[1]);
  endtask

  typedef struct {
    bit rst;
    bit col;
    bit exp_f;
    bit exp_nf;
  } vec_t;

  vec_t vecs[20];

  initial begin
    vecs[0]  = '{1, 1, 0, 0};
    vecs[1]  = '{0, 1, 0, 0};
    vecs[2]  = '{0, 1, 0, 0};
    vecs[3]  = '{0, 1, 0, 0};
    vecs[4]  = '{0, 1, 0, 0};
    vecs[5]  = '{0, 1, 0, 0};
    vecs[6]  = '{0, 1, 0, 1};
    vecs[7]  = '{0, 1, 1, 1};
    vecs[8]  = '{0, 0, 1, 1};
    vecs[9]  = '{0, 1, 1, 1};
    vecs[10] = '{1, 1, 0, 0};
    vecs[11] = '{0, 0, 0, 0};
    vecs[12] = '{0, 0, 0, 0};
    vecs[13] = '{0, 0, 0, 0};
    vecs[14] = '{0, 0, 0, 0};
    vecs[15] = '{0, 0, 0, 0};
    vecs[16] = '{0, 1, 0, 1};
    vecs[17] = '{0, 0, 0, 1};
    vecs[18] = '{0, 1, 0, 1};
    vecs[19] = '{1, 0, 0, 0};

    for (int i = 0; i < 20; i++) begin
      cycle(vecs[i].rst, vecs[i].col, "table");
      chk($sformatf("table[%0d]", i), go0, FILT_ON ? vecs[i].exp_f : vecs[i].exp_nf);
    end

    // Idle after reset never ends the game.
    cycle(1, 0, "idle_rst");
    for (int i = 0; i < 12; i++) cycle(0, 0, "idle");
    chk("idle_end", go0, 1'b0);

    // Collision held through the grace window and well beyond.
    cycle(1, 0, "hold_rst");
    for (int i = 0; i < 105; i++) cycle(0, 1, "hold");
    chk("hold_end", go0, 1'b1);

    // Alternating collision in PLAYING.
    cycle(1, 0, "alt_rst");
    for (int i = 0; i < 5; i++) cycle(0, 0, "alt_arm");
    for (int i = 0; i < 6; i++) cycle(0, (i % 2) == 0, "alt");
    chk("alt_end", go0, !FILT_ON);

    // Force GAME_OVER, then collision low for a long time.
    cycle(1, 0, "low_rst");
    for (int i = 0; i < 5; i++) cycle(0, 0, "low_arm");
    for (int i = 0; i < 3; i++) cycle(0, 1, "low_hit");
    chk("low_over", go0, 1'b1);
    for (int i = 0; i < 50; i++) cycle(0, 0, "low_hold");
    chk("low_end", go0, 1'b1);

    // Reset out of GAME_OVER, then long reset with collision asserted.
    cycle(1, 0, "rst_exit");
    chk("rst_exit_val", go0, 1'b0);
    for (int i = 0; i < 100; i++) cycle(1, 1, "rst_hold");
    chk("rst_hold_end", go1, 1'b0);

    // Randomized traffic with shifting collision density.
    begin
      int p;
      p = 50;
      for (int i = 0; i < 3000; i++) begin
        bit r, c;
        if ((i % 50) == 0) p = 5 + 40 * $urandom_range(0, 2);
        r = ($urandom_range(0, 59) == 0);
        c = ($urandom_range(0, 99) < p);
        cycle(r, c, "rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
